pixel_stream_proc: RTL and testbench

Parametrised, pipelined pixel-point processor for the image path. Accepts a valid/ready pixel stream and applies one of six per-pixel operations: saturating brighten, saturating darken, binarise, invert, clamp or pass. Configuration is frozen per frame, and the block marks the last pixel of each frame. It sits between the frame-memory reader and the frame-memory writer, and optionally publishes per-frame statistics.

---
 rtl/pixel_stream_proc.sv | 165 ++++++++++++++++
 tb/tb_pixel_stream_proc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_proc.sv
// Two-stage valid/ready pixel-point processor: brighten, darken, binarise, invert, clamp or pass.
// Optional per-frame output statistics are built when the STATS_EN macro is defined.
module pixel_stream_proc #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 98304,
  localparam int CNT_W       = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cfg_select,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [DATA_W-1:0] cfg_threshold,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_done,
  output logic              busy
`ifdef STATS_EN
  ,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [CNT_W:0]    stat_clip
`endif
);

  localparam logic [DATA_W-1:0] MAX = '1;

  // Result is {clip, pixel}.
  function automatic logic [DATA_W:0] point_op(input logic [2:0] mode,
                                               input logic [DATA_W-1:0] pix,
                                               input logic [DATA_W-1:0] val,
                                               input logic [DATA_W-1:0] thr);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] hi_cut;
    logic              hi_clip;
    sum     = {1'b0, pix} + {1'b0, val};
    hi_clip = pix > thr;
    hi_cut  = hi_clip ? thr : pix;
    case (mode)
      3'd0: point_op = sum[DATA_W] ? {1'b1, MAX} : {1'b0, sum[DATA_W-1:0]};
      3'd1: point_op = (pix < val) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, pix - val};
      3'd2: point_op = {1'b0, (pix >= thr) ? MAX : {DATA_W{1'b0}}};
      3'd3: point_op = {1'b0, MAX - pix};
      // upper bound applied first so the lower bound has the final say
      3'd5: point_op = (hi_cut < val) ? {1'b1, val} : {hi_clip, hi_cut};
      default: point_op = {1'b0, pix};
    endcase
  endfunction

  logic [CNT_W-1:0]  in_cnt;
  logic [2:0]        mode_sh;
  logic [DATA_W-1:0] val_sh, thr_sh;
  logic [2:0]        mode_eff;
  logic [DATA_W-1:0] val_eff, thr_eff;
  logic [DATA_W:0]   op_res;
  logic              advance, accept, at_first, at_last;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] data_p1;

  assign advance  = !m_valid || m_ready;
  assign s_ready  = rst_n && advance;
  assign accept   = s_valid && s_ready;
  assign at_first = in_cnt == '0;
  assign at_last  = in_cnt == CNT_W'(FRAME_PIXELS - 1);
  assign busy     = !at_first || vld_p1 || m_valid;

  always_comb begin
    mode_eff = mode_sh;
    val_eff  = val_sh;
    thr_eff  = thr_sh;
    if (at_first) begin
      mode_eff = cfg_select;
      val_eff  = cfg_value;
      thr_eff  = cfg_threshold;
    end
  end

  assign op_res = point_op(mode_eff, s_data, val_eff, thr_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt     <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept) in_cnt <= at_last ? '0 : in_cnt + CNT_W'(1);
      if (advance) begin
        vld_p1  <= accept;
        last_p1 <= accept && at_last;
        m_valid <= vld_p1;
        m_last  <= last_p1;
        m_data  <= data_p1;
      end
      frame_done <= m_valid && m_ready && m_last;
    end
  end

  // Stage S1: shadow config capture and operation result.
  always_ff @(posedge clk) begin
    if (accept && at_first) begin
      mode_sh <= cfg_select;
      val_sh  <= cfg_value;
      thr_sh  <= cfg_threshold;
    end
    if (advance) data_p1 <= op_res[DATA_W-1:0];
  end

`ifdef STATS_EN
  logic              clip_p1, clip_p2, xfer;
  logic [DATA_W-1:0] acc_min, acc_max, nxt_min, nxt_max;
  logic [CNT_W:0]    acc_clip, nxt_clip;

  // Stage S2: clip flag travels with the output pixel.
  always_ff @(posedge clk) begin
    if (advance) begin
      clip_p1 <= op_res[DATA_W];
      clip_p2 <= clip_p1;
    end
  end

  assign xfer = m_valid && m_ready;

  always_comb begin
    nxt_min  = (m_data < acc_min) ? m_data : acc_min;
    nxt_max  = (m_data > acc_max) ? m_data : acc_max;
    nxt_clip = acc_clip + (CNT_W + 1)'(clip_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min   <= MAX;
      acc_max   <= '0;
      acc_clip  <= '0;
      stat_min  <= MAX;
      stat_max  <= '0;
      stat_clip <= '0;
    end else if (xfer) begin
      if (m_last) begin
        stat_min  <= nxt_min;
        stat_max  <= nxt_max;
        stat_clip <= nxt_clip;
        acc_min   <= MAX;
        acc_max   <= '0;
        acc_clip  <= '0;
      end else begin
        acc_min  <= nxt_min;
        acc_max  <= nxt_max;
        acc_clip <= nxt_clip;
      end
    end
  end
`else
  logic unused_clip;
  assign unused_clip = op_res[DATA_W];
`endif

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Directed bench for pixel_stream_proc with 4-pixel frames and 8-bit pixels.
// Frame vectors come from a table; backpressure, mid-frame cfg change and reset are hand sequences.
module tb_pixel_stream_proc;

  localparam int DW = 8;
  localparam int FP = 4;
  localparam int CW = $clog2(FP);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    cfg_select;
  logic [DW-1:0] cfg_value, cfg_threshold;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last, frame_done, busy;
  logic [DW-1:0] m_data;
`ifdef STATS_EN
  logic [DW-1:0] stat_min, stat_max;
  logic [CW:0]   stat_clip;
`endif

  pixel_stream_proc #(.DATA_W(DW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_select(cfg_select), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_done(frame_done), .busy(busy)
`ifdef STATS_EN
    , .stat_min(stat_min), .stat_max(stat_max), .stat_clip(stat_clip)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]         sel;
    logic [7:0]         val;
    logic [7:0]         thr;
    logic [3:0][7:0]    pix;
    logic [3:0][7:0]    exp;
    logic [3:0]         clip;
  } vec_t;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // m_ready changes just after the rising edge so it is stable at every sample point
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push(input logic [2:0] sel, input logic [7:0] val, input logic [7:0] thr,
                      input logic [7:0] d);
    int guard;
    @(negedge clk);
    cfg_select = sel; cfg_value = val; cfg_threshold = thr;
    s_data = d; s_valid = 1'b1;
    #1;
    guard = 0;
    while (!s_ready && guard < 500) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 500) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int guard;
    guard = 0;
    while (q_data.size() < n && guard < 500) begin
      @(negedge clk); #1; guard++;
    end
    if (q_data.size() < n) check("output_timeout", 32'(q_data.size()), 32'(n));
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] val, input logic [7:0] thr,
                              input logic [7:0] p0, p1, p2, p3,
                              input logic [7:0] e0, e1, e2, e3, input logic [3:0] clip);
    vec_t v;
    v.sel = sel; v.val = val; v.thr = thr;
    v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2; v.pix[3] = p3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.clip = clip;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    int base, fd0, idx;
    logic [7:0] emin, emax, p;
    logic [7:0] bp_exp[12];

    vecs[0] = mk(3'd0, 8'd60, 8'd0,   8'd10, 8'd200, 8'd195, 8'd255, 8'd70, 8'd255, 8'd255, 8'd255, 4'd3);
    vecs[1] = mk(3'd1, 8'd60, 8'd0,   8'd59, 8'd60,  8'd61,  8'd0,   8'd0,  8'd0,   8'd1,   8'd0,   4'd2);
    vecs[2] = mk(3'd2, 8'd0,  8'd160, 8'd159, 8'd160, 8'd0,  8'd255, 8'd0,  8'd255, 8'd0,   8'd255, 4'd0);
    vecs[3] = mk(3'd5, 8'd20, 8'd100, 8'd5,  8'd50,  8'd150, 8'd100, 8'd20, 8'd50,  8'd100, 8'd100, 4'd2);
    vecs[4] = mk(3'd3, 8'd0,  8'd0,   8'h12, 8'h00,  8'hFF,  8'h80,  8'hED, 8'hFF,  8'h00,  8'h7F,  4'd0);
    vecs[5] = mk(3'd7, 8'd9,  8'd9,   8'd1,  8'd2,   8'd3,   8'd250, 8'd1,  8'd2,   8'd3,   8'd250, 4'd0);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_select = '0; cfg_value = '0; cfg_threshold = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef STATS_EN
    check("rst_stat_min", 32'(stat_min), 32'd255);
    check("rst_stat_max", 32'(stat_max), 32'd0);
    check("rst_stat_clip", 32'(stat_clip), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      base = q_data.size(); fd0 = fd_cnt;
      for (int i = 0; i < 4; i++) push(vecs[v].sel, vecs[v].val, vecs[v].thr, vecs[v].pix[i]);
      wait_outputs(base + 4);
      repeat (2) @(negedge clk);
      emin = 8'd255; emax = 8'd0;
      for (int i = 0; i < 4; i++) begin
        if (q_data.size() > base + i) begin
          check($sformatf("vec%0d_data%0d", v, i), 32'(q_data[base+i]), 32'(vecs[v].exp[i]));
          check($sformatf("vec%0d_last%0d", v, i), 32'(q_last[base+i]), 32'(i == 3));
        end
        if (vecs[v].exp[i] < emin) emin = vecs[v].exp[i];
        if (vecs[v].exp[i] > emax) emax = vecs[v].exp[i];
      end
      check($sformatf("vec%0d_frame_done", v), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
`ifdef STATS_EN
      check($sformatf("vec%0d_stat_min", v), 32'(stat_min), 32'(emin));
      check($sformatf("vec%0d_stat_max", v), 32'(stat_max), 32'(emax));
      check($sformatf("vec%0d_stat_clip", v), 32'(stat_clip), 32'(vecs[v].clip));
`endif
    end

    // Random backpressure over three back-to-back mode-0 frames.
    base = q_data.size(); fd0 = fd_cnt;
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      p = 8'($urandom_range(0, 255));
      bp_exp[i] = (int'(p) + 5 > 255) ? 8'd255 : p + 8'd5;
      push(3'd0, 8'd5, 8'd0, p);
    end
    wait_outputs(base + 12);
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("bp_count", 32'(q_data.size() - base), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (q_data.size() > base + i) begin
        check($sformatf("bp_data%0d", i), 32'(q_data[base+i]), 32'(bp_exp[i]));
        check($sformatf("bp_last%0d", i), 32'(q_last[base+i]), 32'(i % 4 == 3));
      end
    end
    check("bp_frame_done", 32'(fd_cnt - fd0), 32'd3);

    // cfg_select moves 0->3 mid-frame; the next frame follows with no gap.
    base = q_data.size(); fd0 = fd_cnt;
    push(3'd0, 8'd60, 8'd0, 8'd10);
    push(3'd0, 8'd60, 8'd0, 8'd20);
    push(3'd3, 8'd60, 8'd0, 8'd30);
    push(3'd3, 8'd60, 8'd0, 8'd40);
    push(3'd3, 8'd60, 8'd0, 8'd10);
    push(3'd3, 8'd60, 8'd0, 8'd20);
    push(3'd3, 8'd60, 8'd0, 8'd30);
    push(3'd3, 8'd60, 8'd0, 8'd40);
    wait_outputs(base + 8);
    repeat (2) @(negedge clk);
    begin
      logic [7:0] cexp[8];
      cexp = '{8'd70, 8'd80, 8'd90, 8'd100, 8'd245, 8'd235, 8'd225, 8'd215};
      for (int i = 0; i < 8; i++)
        if (q_data.size() > base + i)
          check($sformatf("cfgchg_data%0d", i), 32'(q_data[base+i]), 32'(cexp[i]));
    end
    if (q_cyc.size() > base + 4)
      check("cfgchg_no_gap", 32'(q_cyc[base+4] - q_cyc[base+3]), 32'd1);
    check("cfgchg_frame_done", 32'(fd_cnt - fd0), 32'd2);

    // Reset after two pixels of a stalled frame.
    ready_mode = 2;
    @(negedge clk); @(negedge clk);
    base = q_data.size(); fd0 = fd_cnt;
    push(3'd0, 8'd60, 8'd0, 8'd10);
    push(3'd0, 8'd60, 8'd0, 8'd20);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    check("midrst_stalled_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_output", 32'(q_data.size() - base), 32'd0);
    check("midrst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    for (int i = 0; i < 4; i++) push(3'd3, 8'd0, 8'd0, 8'(i + 1));
    wait_outputs(base + 4);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      idx = base + i;
      if (q_data.size() > idx) begin
        check($sformatf("postrst_data%0d", i), 32'(q_data[idx]), 32'(8'd254 - 8'(i)));
        check($sformatf("postrst_last%0d", i), 32'(q_last[idx]), 32'(i == 3));
      end
    end
    check("postrst_frame_done", 32'(fd_cnt - fd0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
